alu_mc: RTL and testbench

Multi-cycle, parametrised successor to the datapath ALU for the pipelined/multi-cycle LEGv8 core. Adds a valid/ready handshake, registered NZCV flags (for ADDS/SUBS/CBZ/B.cond), logical shifts, and an iterative shift-add multiplier (MUL/UMULH). It sits in the execute stage. The stage stalls on `in_ready`/`out_valid` while a multiply iterates.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mul_seq.sv | 42 ++++
 rtl/alu_mc.sv | 112 +++++++++++
 tb/tb_alu_mc.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag bundle shared by the multi-cycle ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_LSL   = 4'b0011,
        OP_LSR   = 4'b0100,
        OP_SUB   = 4'b0110,
        OP_PASSB = 4'b0111,
        OP_MUL   = 4'b1000,
        OP_UMULH = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } alu_state_e;

    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle between execute stage and ALU
interface alu_mc_if #(parameter int N = 64) ();
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;

    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, result, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, result, zero, negative, carry, overflow
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier iterating one multiplier bit per step into a 2N accumulator
module alu_mul_seq #(parameter int N = 64) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic [2*N-1:0] acc_next,
    output logic           done
);
    localparam int CW = $clog2(N) + 1;

    logic [2*N-1:0] acc;
    logic [2*N-1:0] mcand_sh;
    logic [N-1:0]   mplier_sh;
    logic [CW-1:0]  count;

    // acc_next is exposed so the caller can capture the final sum on the same edge it is formed
    assign acc_next = acc + (mplier_sh[0] ? mcand_sh : '0);
    assign done     = step && count == CW'(N - 1);

    // load clears the accumulator; each step adds the shifted multiplicand when the current bit is set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            count     <= '0;
        end else if (load) begin
            acc       <= '0;
            mcand_sh  <= {{N{1'b0}}, mcand};
            mplier_sh <= mplier;
            count     <= '0;
        end else if (step) begin
            acc       <= acc_next;
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            count     <= count + 1'b1;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked execute-stage ALU with registered NZCV flags and an iterative multiplier
module alu_mc
    import alu_pkg::*;
#(
    parameter int N = 64
) (
    input logic  clk,
    input logic  reset,
    alu_mc_if.slave bus
);
    localparam int SW = $clog2(N);

    alu_state_e     state;
    alu_op_e        op;
    flags_t         flags;
    flags_t         sc_flags;
    flags_t         mul_flags;
    logic [N-1:0]   result;
    logic [N-1:0]   sc_res;
    logic [N-1:0]   mul_res;
    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [2*N-1:0] acc_next;
    logic           hi;
    logic           accept;
    logic           is_mul;
    logic           mul_last;

    assign op            = alu_op_e'(bus.ALUControl);
    assign is_mul        = op == OP_MUL || op == OP_UMULH;
    assign bus.in_ready  = state == S_IDLE || (state == S_DONE && bus.out_ready);
    assign bus.out_valid = state == S_DONE;
    assign accept        = bus.in_valid && bus.in_ready;
    assign sum           = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff          = {1'b0, bus.a} - {1'b0, bus.b};
    assign mul_res       = hi ? acc_next[2*N-1:N] : acc_next[N-1:0];
    assign bus.result    = result;
    assign bus.zero      = flags.zero;
    assign bus.negative  = flags.negative;
    assign bus.carry     = flags.carry;
    assign bus.overflow  = flags.overflow;

    alu_mul_seq #(.N(N)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && is_mul),
        .step     (state == S_MUL),
        .mcand    (bus.a),
        .mplier   (bus.b),
        .acc_next (acc_next),
        .done     (mul_last)
    );

    // single-cycle datapath; carry on SUB is inverted borrow
    always_comb begin
        sc_res            = '0;
        sc_flags.carry    = 1'b0;
        sc_flags.overflow = 1'b0;
        case (op)
            OP_AND:   sc_res = bus.a & bus.b;
            OP_OR:    sc_res = bus.a | bus.b;
            OP_PASSB: sc_res = bus.b;
            OP_LSL:   sc_res = bus.a << bus.b[SW-1:0];
            OP_LSR:   sc_res = bus.a >> bus.b[SW-1:0];
            OP_ADD: begin
                sc_res            = sum[N-1:0];
                sc_flags.carry    = sum[N];
                sc_flags.overflow = bus.a[N-1] == bus.b[N-1] && sum[N-1] != bus.a[N-1];
            end
            OP_SUB: begin
                sc_res            = diff[N-1:0];
                sc_flags.carry    = !diff[N];
                sc_flags.overflow = bus.a[N-1] != bus.b[N-1] && diff[N-1] != bus.a[N-1];
            end
            default:  sc_res = '0;
        endcase
        sc_flags.zero     = sc_res == '0;
        sc_flags.negative = sc_res[N-1];
    end

    // multiply results never set carry or overflow
    always_comb begin
        mul_flags          = '0;
        mul_flags.zero     = mul_res == '0;
        mul_flags.negative = mul_res[N-1];
    end

    // control FSM; DONE accepts a new op on the same edge its result is consumed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            result <= '0;
            flags  <= '0;
            hi     <= 1'b0;
        end else if (state == S_MUL) begin
            if (mul_last) begin
                result <= mul_res;
                flags  <= mul_flags;
                state  <= S_DONE;
            end
        end else if (accept) begin
            state <= is_mul ? S_MUL : S_DONE;
            hi    <= op == OP_UMULH;
            if (!is_mul) begin
                result <= sc_res;
                flags  <= sc_flags;
            end
        end else if (state == S_DONE && bus.out_ready) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: table and scoreboard checks of alu_mc at N=64 and N=8
module tb_alu_mc;

    typedef struct {
        bit          w8;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb[$];
    vec_t tbl[16];

    alu_mc_if #(.N(64)) i64 ();
    alu_mc_if #(.N(8))  i8 ();

    alu_mc #(.N(64)) u64 (.clk(clk), .reset(rst_n), .bus(i64));
    alu_mc #(.N(8))  u8  (.clk(clk), .reset(rst_n), .bus(i8));

    always #5 clk = ~clk;

    function automatic logic rdy(bit w8);
        return w8 ? i8.in_ready : i64.in_ready;
    endfunction

    function automatic logic ov(bit w8);
        return w8 ? i8.out_valid : i64.out_valid;
    endfunction

    function automatic logic [63:0] res(bit w8);
        return w8 ? {56'b0, i8.result} : i64.result;
    endfunction

    function automatic logic [3:0] fl(bit w8);
        return w8 ? {i8.zero, i8.negative, i8.carry, i8.overflow}
                  : {i64.zero, i64.negative, i64.carry, i64.overflow};
    endfunction

    function automatic logic signed [127:0] sx(logic [63:0] x, int n);
        return $signed({64'b0, x}) - (x[n-1] ? (128'sd1 <<< n) : 128'sd0);
    endfunction

    // reference model built from plain integer arithmetic
    function automatic vec_t model(bit w8, logic [3:0] op, logic [63:0] ai, logic [63:0] bi);
        vec_t v;
        int n;
        logic [63:0] m, a, b, r;
        logic [127:0] p;
        logic signed [127:0] sa, sb_, lim;
        logic c, o;
        n = w8 ? 8 : 64;
        m = w8 ? 64'hFF : '1;
        a = ai & m;
        b = bi & m;
        p = {64'b0, a} * {64'b0, b};
        sa = sx(a, n);
        sb_ = sx(b, n);
        lim = 128'sd1 <<< (n - 1);
        r = '0;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = (a + b) & m;
                c = ({64'b0, a} + {64'b0, b}) > {64'b0, m};
                o = (sa + sb_ >= lim) || (sa + sb_ < -lim);
            end
            4'b0110: begin
                r = (a - b) & m;
                c = a >= b;
                o = (sa - sb_ >= lim) || (sa - sb_ < -lim);
            end
            4'b0111: r = b;
            4'b0011: r = (a << (b & 64'(n - 1))) & m;
            4'b0100: r = a >> (b & 64'(n - 1));
            4'b1000: r = p[63:0] & m;
            4'b1001: begin
                p = p >> n;
                r = p[63:0] & m;
            end
            default: r = '0;
        endcase
        v.w8 = w8;
        v.op = op;
        v.a = ai;
        v.b = bi;
        v.res = r;
        v.fl = {r == 0, r[n-1], c, o};
        v.lat = (op == 4'b1000 || op == 4'b1001) ? n + 1 : 1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit w8, input logic v, input logic [3:0] op,
                          input logic [63:0] a, input logic [63:0] b);
        if (w8) begin
            i8.in_valid = v;
            i8.ALUControl = op;
            i8.a = a[7:0];
            i8.b = b[7:0];
        end else begin
            i64.in_valid = v;
            i64.ALUControl = op;
            i64.a = a;
            i64.b = b;
        end
    endtask

    task automatic check_reset(input bit w8);
        chk("rst_out_valid", 64'(ov(w8)), 64'd0);
        chk("rst_in_ready", 64'(rdy(w8)), 64'd1);
        chk("rst_result", res(w8), 64'd0);
        chk("rst_flags", 64'(fl(w8)), 64'd0);
    endtask

    // issue one op, push its expectation at accept, pop and compare when out_valid rises
    task automatic do_op(input vec_t v);
        vec_t e;
        int lat, stall;
        @(negedge clk);
        set_in(v.w8, 1'b1, v.op, v.a, v.b);
        lat = 0;
        while (!rdy(v.w8) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("accept_wait", 64'(rdy(v.w8)), 64'd1);
        @(posedge clk);
        sb.push_back(v);
        #1 set_in(v.w8, 1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
        @(negedge clk);
        lat = 1;
        stall = 0;
        while (!ov(v.w8) && lat < 200) begin
            if (!rdy(v.w8)) stall++;
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", 64'(lat), 64'(e.lat));
        chk("in_ready_low", 64'(stall), 64'(e.lat - 1));
        chk("result", res(v.w8), e.res);
        chk("flags", 64'(fl(v.w8)), 64'(e.fl));
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1010, 1};
        tbl[1]  = '{1'b0, 4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1};
        tbl[2]  = '{1'b0, 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000, 1};
        tbl[3]  = '{1'b0, 4'b0110, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1};
        tbl[4]  = '{1'b0, 4'b0100, 64'h8000_0000_0000_0000, 64'h41, 64'h4000_0000_0000_0000, 4'b0000, 1};
        tbl[5]  = '{1'b0, 4'b1000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 4'b1000, 65};
        tbl[6]  = '{1'b0, 4'b1001, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 4'b0000, 65};
        tbl[7]  = '{1'b0, 4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100, 65};
        tbl[8]  = '{1'b0, 4'b0111, 64'hDEAD, 64'h1234, 64'h1234, 4'b0000, 1};
        tbl[9]  = '{1'b1, 4'b1000, 64'hFF, 64'hFF, 64'h01, 4'b0000, 9};
        tbl[10] = '{1'b1, 4'b1001, 64'hFF, 64'hFF, 64'hFE, 4'b0100, 9};
        tbl[11] = '{1'b1, 4'b0011, 64'h81, 64'h0B, 64'h08, 4'b0000, 1};
        tbl[12] = '{1'b1, 4'b1111, 64'h81, 64'h0B, 64'h00, 4'b1000, 1};
        tbl[13] = '{1'b1, 4'b0010, 64'h7F, 64'h01, 64'h80, 4'b0101, 1};
        tbl[14] = '{1'b1, 4'b0110, 64'h05, 64'h05, 64'h00, 4'b1010, 1};
        tbl[15] = '{1'b1, 4'b0010, 64'h80, 64'h80, 64'h00, 4'b1011, 1};
        set_in(1'b0, 1'b0, 4'b0, 64'd0, 64'd0);
        set_in(1'b1, 1'b0, 4'b0, 64'd0, 64'd0);
        i64.out_ready = 1'b1;
        i8.out_ready = 1'b1;
        #12;
        check_reset(1'b0);
        check_reset(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (tbl[i]) do_op(tbl[i]);
        for (int i = 0; i < 24; i++)
            do_op(model(i[0], 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}));

        // back-pressure: AND result held while a pending OR waits, then OR taken on the handshake edge
        @(negedge clk);
        i64.out_ready = 1'b0;
        set_in(1'b0, 1'b1, 4'b0000, 64'hFF00FF, 64'h0FF0F0);
        @(posedge clk);
        #1 set_in(1'b0, 1'b1, 4'b0001, 64'hFF00FF, 64'h0FF0F0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(i64.out_valid), 64'd1);
            chk("bp_in_ready", 64'(i64.in_ready), 64'd0);
            chk("bp_result", i64.result, 64'h0F00F0);
        end
        i64.out_ready = 1'b1;
        #1 chk("bp_ready_follow", 64'(i64.in_ready), 64'd1);
        @(posedge clk);
        #1 set_in(1'b0, 1'b0, 4'b0000, 64'd0, 64'd0);
        @(negedge clk);
        chk("bp_or_valid", 64'(i64.out_valid), 64'd1);
        chk("bp_or_result", i64.result, 64'hFFF0FF);

        // reset three cycles into an N=8 multiply aborts it
        do_op(model(1'b1, 4'b0001, 64'h0F, 64'hF0));
        @(negedge clk);
        set_in(1'b1, 1'b1, 4'b1000, 64'hFF, 64'hFF);
        @(posedge clk);
        #1 set_in(1'b1, 1'b0, 4'b0, 64'd0, 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(i8.in_ready), 64'd1);
        do_op('{1'b1, 4'b0010, 64'd2, 64'd3, 64'd5, 4'b0000, 1});

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
